// File: rtl/mpei_rv_core_wrapper.sv
// I/O shell of the MPEI RISC-V MCU.
// Every used pad input is synchronized by two flops. The registered GPIO, UART,
// SPI and timer pad outputs run in fixed default modes: GPIO input sampling,
// UART loopback with baud ticks, SPI idle, and a free-running timer/watchdog.
module mpei_rv_core_wrapper #(
  parameter int          slvselsz           = 1,
  parameter int          NAHBIRQ            = 32,
  parameter int          SCR1_XLEN          = 32,
  parameter int          SCR1_IRQ_LINES_NUM = 16,
  parameter int          SCR1_AHB_WIDTH     = 32,
  parameter logic [31:0] UART_SCALER        = 32'd53,
  parameter logic [31:0] TIMER_RELOAD       = 32'd999,
  parameter logic [31:0] WDOG_RELOAD        = 32'd15
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                spi_in_miso,
  input  logic                spi_in_mosi,
  input  logic                spi_in_sck,
  input  logic                spi_in_spisel,
  input  logic                spi_in_astart,
  input  logic                spi_in_cstart,
  input  logic                spi_in_ignore,
  input  logic                spi_in_io2,
  input  logic                spi_in_io3,
  output logic                spi_out_miso,
  output logic                spi_out_misooen,
  output logic                spi_out_mosi,
  output logic                spi_out_mosioen,
  output logic                spi_out_sck,
  output logic                spi_out_sckoen,
  output logic                spi_out_enable,
  output logic                spi_out_astart,
  output logic                spi_out_aready,
  output logic                spi_out_io2,
  output logic                spi_out_io2oen,
  output logic                spi_out_io3,
  output logic                spi_out_io3oen,
  output logic [slvselsz-1:0] spi_out_slvsel,
  input  logic                uart_in_rxd,
  input  logic                uart_in_ctsn,
  input  logic                uart_in_extclk,
  output logic                uart_out_rtsn,
  output logic                uart_out_txd,
  output logic                uart_out_txen,
  output logic                uart_out_flow,
  output logic                uart_out_rxen,
  output logic                uart_out_txtick,
  output logic                uart_out_rxtick,
  output logic [31:0]         uart_out_scaler,
  input  logic [31:0]         gpio_in_din,
  input  logic [31:0]         gpio_in_sig_in,
  input  logic [31:0]         gpio_in_sig_en,
  output logic [31:0]         gpio_out_dout,
  output logic [31:0]         gpio_out_oen,
  output logic [31:0]         gpio_out_val,
  output logic [31:0]         gpio_out_sig_out,
  input  logic                timr_in_dhalt,
  input  logic                timr_in_extclk,
  input  logic                timr_in_wdogen,
  input  logic [NAHBIRQ-1:0]  timr_in_latchv,
  input  logic [NAHBIRQ-1:0]  timr_in_latchd,
  output logic [0:7]          timr_out_tick,
  output logic [31:0]         timr_out_timer1,
  output logic                timr_out_wdogn,
  output logic                timr_out_wdog
);

  // _p0 is the first synchronizer flop, _p1 the synchronized value
  logic [31:0] din_p0, din_p1, sig_in_p0, sig_in_p1, sig_en_p0, sig_en_p1;
  logic        rxd_p0, rxd_p1, ctsn_p0, ctsn_p1, spisel_p0, spisel_p1;
  logic        dhalt_p0, dhalt_p1, wdogen_p0, wdogen_p1;

  logic [31:0] gpio_val_p2, gpio_sig_p2;
  logic        txd_p2, rtsn_p2;
  logic [31:0] baud_cnt;
  logic        txtick, rxtick;
  logic [31:0] timer1;
  logic        tick0, tick1;
  logic [31:0] wdog_cnt;
  logic        wdog;
  logic        underflow;

  // Two-flop synchronizers; idle-high UART/SPI select lines reset to 1
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      din_p0    <= '0;   din_p1    <= '0;
      sig_in_p0 <= '0;   sig_in_p1 <= '0;
      sig_en_p0 <= '0;   sig_en_p1 <= '0;
      rxd_p0    <= 1'b1; rxd_p1    <= 1'b1;
      ctsn_p0   <= 1'b1; ctsn_p1   <= 1'b1;
      spisel_p0 <= 1'b1; spisel_p1 <= 1'b1;
      dhalt_p0  <= 1'b0; dhalt_p1  <= 1'b0;
      wdogen_p0 <= 1'b0; wdogen_p1 <= 1'b0;
    end else begin
      din_p0    <= gpio_in_din;    din_p1    <= din_p0;
      sig_in_p0 <= gpio_in_sig_in; sig_in_p1 <= sig_in_p0;
      sig_en_p0 <= gpio_in_sig_en; sig_en_p1 <= sig_en_p0;
      rxd_p0    <= uart_in_rxd;    rxd_p1    <= rxd_p0;
      ctsn_p0   <= uart_in_ctsn;   ctsn_p1   <= ctsn_p0;
      spisel_p0 <= spi_in_spisel;  spisel_p1 <= spisel_p0;
      dhalt_p0  <= timr_in_dhalt;  dhalt_p1  <= dhalt_p0;
      wdogen_p0 <= timr_in_wdogen; wdogen_p1 <= wdogen_p0;
    end
  end

  // ---- stage p2: registered GPIO sampling and UART loopback ----
  // Register synchronized GPIO inputs and loop RX back onto TX
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      gpio_val_p2 <= '0;
      gpio_sig_p2 <= '0;
      txd_p2      <= 1'b1;
      rtsn_p2     <= 1'b1;
    end else begin
      gpio_val_p2 <= din_p1;
      gpio_sig_p2 <= sig_in_p1 & sig_en_p1;
      txd_p2      <= rxd_p1;
      rtsn_p2     <= ctsn_p1;
    end
  end

  // Baud counter: period UART_SCALER+1, TX tick at 0, RX tick at mid-count
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      baud_cnt <= UART_SCALER;
      txtick   <= 1'b0;
      rxtick   <= 1'b0;
    end else begin
      baud_cnt <= (baud_cnt == '0) ? UART_SCALER : baud_cnt - 32'd1;
      txtick   <= (baud_cnt == '0);
      rxtick   <= (baud_cnt == (UART_SCALER >> 1));
    end
  end

  // Underflow is the active cycle in which timer1 wraps back to its reload
  assign underflow = !dhalt_p1 && (timer1 == '0);

  // Free-running timer1 with prescaler and underflow ticks, frozen by dhalt
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      timer1 <= TIMER_RELOAD;
      tick0  <= 1'b0;
      tick1  <= 1'b0;
    end else begin
      tick0 <= !dhalt_p1;
      tick1 <= underflow;
      if (!dhalt_p1)
        timer1 <= (timer1 == '0) ? TIMER_RELOAD : timer1 - 32'd1;
    end
  end

  // Watchdog counts enabled underflows; bites one underflow after reaching 0, sticky
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      wdog_cnt <= WDOG_RELOAD;
      wdog     <= 1'b0;
    end else if (underflow && wdogen_p1) begin
      if (wdog_cnt == '0)
        wdog <= 1'b1;
      else
        wdog_cnt <= wdog_cnt - 32'd1;
    end
  end

  assign gpio_out_val     = gpio_val_p2;
  assign gpio_out_sig_out = gpio_sig_p2;
  assign gpio_out_dout    = '0;
  assign gpio_out_oen     = '0;

  assign uart_out_txd     = txd_p2;
  assign uart_out_rtsn    = rtsn_p2;
  assign uart_out_scaler  = UART_SCALER;
  assign uart_out_txen    = 1'b1;
  assign uart_out_rxen    = 1'b1;
  assign uart_out_flow    = 1'b0;
  assign uart_out_txtick  = txtick;
  assign uart_out_rxtick  = rxtick;

  assign spi_out_sck      = 1'b0;
  assign spi_out_mosi     = 1'b1;
  assign spi_out_miso     = 1'b1;
  assign spi_out_io2      = 1'b1;
  assign spi_out_io3      = 1'b1;
  assign spi_out_misooen  = 1'b1;
  assign spi_out_mosioen  = 1'b1;
  assign spi_out_sckoen   = 1'b1;
  assign spi_out_io2oen   = 1'b1;
  assign spi_out_io3oen   = 1'b1;
  assign spi_out_enable   = 1'b0;
  assign spi_out_astart   = 1'b0;
  assign spi_out_aready   = 1'b1;
  assign spi_out_slvsel   = '1;

  assign timr_out_timer1  = timer1;
  assign timr_out_tick    = {tick0, tick1, 6'b000000};
  assign timr_out_wdog    = wdog;
  assign timr_out_wdogn   = !wdog;

  // Pad inputs and integration parameters that have no function in the default modes
  logic unused_inputs;
  assign unused_inputs = ^{spi_in_miso, spi_in_mosi, spi_in_sck, spi_in_astart,
                           spi_in_cstart, spi_in_ignore, spi_in_io2, spi_in_io3,
                           spisel_p1, uart_in_extclk, timr_in_extclk,
                           timr_in_latchv, timr_in_latchd,
                           (SCR1_XLEN != 0), (SCR1_IRQ_LINES_NUM != 0),
                           (SCR1_AHB_WIDTH != 0)};

endmodule

// File: tb/tb_mpei_rv_core_wrapper.sv
// Self-checking bench for mpei_rv_core_wrapper: a reference model of the
// default operating modes, table vectors, and hand sequences for ticks,
// timer, watchdog and asynchronous reset.
module tb_mpei_rv_core_wrapper;

  localparam int          UART_P  = 54;     // UART_SCALER + 1
  localparam int          TIMER_P = 1000;   // TIMER_RELOAD + 1
  localparam int          WDOG_N  = 16;     // WDOG_RELOAD + 1 underflows
  localparam logic [31:0] TRELOAD = 32'd999;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        spi_in_miso = 0, spi_in_mosi = 0, spi_in_sck = 0, spi_in_spisel = 1;
  logic        spi_in_astart = 0, spi_in_cstart = 0, spi_in_ignore = 0, spi_in_io2 = 0, spi_in_io3 = 0;
  logic        spi_out_miso, spi_out_misooen, spi_out_mosi, spi_out_mosioen, spi_out_sck, spi_out_sckoen;
  logic        spi_out_enable, spi_out_astart, spi_out_aready, spi_out_io2, spi_out_io2oen, spi_out_io3, spi_out_io3oen;
  logic [0:0]  spi_out_slvsel;
  logic        uart_in_rxd = 1, uart_in_ctsn = 1, uart_in_extclk = 0;
  logic        uart_out_rtsn, uart_out_txd, uart_out_txen, uart_out_flow, uart_out_rxen, uart_out_txtick, uart_out_rxtick;
  logic [31:0] uart_out_scaler;
  logic [31:0] gpio_in_din = 0, gpio_in_sig_in = 0, gpio_in_sig_en = 0;
  logic [31:0] gpio_out_dout, gpio_out_oen, gpio_out_val, gpio_out_sig_out;
  logic        timr_in_dhalt = 0, timr_in_extclk = 0, timr_in_wdogen = 0;
  logic [31:0] timr_in_latchv = 0, timr_in_latchd = 0;
  logic [0:7]  timr_out_tick;
  logic [31:0] timr_out_timer1;
  logic        timr_out_wdogn, timr_out_wdog;

  mpei_rv_core_wrapper dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .spi_in_miso(spi_in_miso), .spi_in_mosi(spi_in_mosi), .spi_in_sck(spi_in_sck),
    .spi_in_spisel(spi_in_spisel), .spi_in_astart(spi_in_astart), .spi_in_cstart(spi_in_cstart),
    .spi_in_ignore(spi_in_ignore), .spi_in_io2(spi_in_io2), .spi_in_io3(spi_in_io3),
    .spi_out_miso(spi_out_miso), .spi_out_misooen(spi_out_misooen), .spi_out_mosi(spi_out_mosi),
    .spi_out_mosioen(spi_out_mosioen), .spi_out_sck(spi_out_sck), .spi_out_sckoen(spi_out_sckoen),
    .spi_out_enable(spi_out_enable), .spi_out_astart(spi_out_astart), .spi_out_aready(spi_out_aready),
    .spi_out_io2(spi_out_io2), .spi_out_io2oen(spi_out_io2oen), .spi_out_io3(spi_out_io3),
    .spi_out_io3oen(spi_out_io3oen), .spi_out_slvsel(spi_out_slvsel),
    .uart_in_rxd(uart_in_rxd), .uart_in_ctsn(uart_in_ctsn), .uart_in_extclk(uart_in_extclk),
    .uart_out_rtsn(uart_out_rtsn), .uart_out_txd(uart_out_txd), .uart_out_txen(uart_out_txen),
    .uart_out_flow(uart_out_flow), .uart_out_rxen(uart_out_rxen), .uart_out_txtick(uart_out_txtick),
    .uart_out_rxtick(uart_out_rxtick), .uart_out_scaler(uart_out_scaler),
    .gpio_in_din(gpio_in_din), .gpio_in_sig_in(gpio_in_sig_in), .gpio_in_sig_en(gpio_in_sig_en),
    .gpio_out_dout(gpio_out_dout), .gpio_out_oen(gpio_out_oen), .gpio_out_val(gpio_out_val),
    .gpio_out_sig_out(gpio_out_sig_out),
    .timr_in_dhalt(timr_in_dhalt), .timr_in_extclk(timr_in_extclk), .timr_in_wdogen(timr_in_wdogen),
    .timr_in_latchv(timr_in_latchv), .timr_in_latchd(timr_in_latchd),
    .timr_out_tick(timr_out_tick), .timr_out_timer1(timr_out_timer1),
    .timr_out_wdogn(timr_out_wdogn), .timr_out_wdog(timr_out_wdog)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad inputs are seen by the logic two clocks late; outputs follow from the
  // count of clocks / active clocks / enabled underflows since reset.
  typedef struct packed {
    logic [31:0] din, sig_in, sig_en;
    logic        rxd, ctsn, dhalt, wdogen;
  } in_t;

  localparam in_t RST_IN = '{din: 32'h0, sig_in: 32'h0, sig_en: 32'h0,
                             rxd: 1'b1, ctsn: 1'b1, dhalt: 1'b0, wdogen: 1'b0};

  in_t         hist[$];
  in_t         seen;
  int unsigned m_cyc, m_act, m_uf;
  logic [31:0] e_val, e_sig, e_timer;
  logic        e_txd, e_rtsn, e_tx, e_rx, e_t0, e_t1, e_wdog;

  always @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      hist.delete();
      hist.push_back(RST_IN);
      hist.push_back(RST_IN);
      m_cyc = 0; m_act = 0; m_uf = 0;
      e_val = 0; e_sig = 0; e_timer = TRELOAD;
      e_txd = 1; e_rtsn = 1; e_tx = 0; e_rx = 0; e_t0 = 0; e_t1 = 0; e_wdog = 0;
    end else begin
      hist.push_back('{din: gpio_in_din, sig_in: gpio_in_sig_in, sig_en: gpio_in_sig_en,
                       rxd: uart_in_rxd, ctsn: uart_in_ctsn, dhalt: timr_in_dhalt,
                       wdogen: timr_in_wdogen});
      seen = hist.pop_front();
      m_cyc++;
      e_val  = seen.din;
      e_sig  = seen.sig_in & seen.sig_en;
      e_txd  = seen.rxd;
      e_rtsn = seen.ctsn;
      e_tx   = (m_cyc % UART_P) == 0;
      e_rx   = (m_cyc % UART_P) == (UART_P - 1) - (UART_P - 1) / 2 + 1;
      e_t0   = !seen.dhalt;
      e_t1   = 1'b0;
      if (!seen.dhalt) begin
        e_t1 = (m_act % TIMER_P) == TIMER_P - 1;
        m_act++;
        e_timer = TRELOAD - 32'(m_act % TIMER_P);
        if (e_t1 && seen.wdogen) m_uf++;
      end
      e_wdog = (m_uf >= WDOG_N);
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    if (rstn_i === 1'b0) begin
      chk("gpio_val", gpio_out_val, e_val);
      chk("gpio_sig", gpio_out_sig_out, e_sig);
      chk("gpio_dout_oen", {gpio_out_dout | gpio_out_oen}, 32'h0);
      chk("uart_txd", uart_out_txd, e_txd);
      chk("uart_rtsn", uart_out_rtsn, e_rtsn);
      chk("uart_txtick", uart_out_txtick, e_tx);
      chk("uart_rxtick", uart_out_rxtick, e_rx);
      chk("uart_const", {uart_out_txen, uart_out_rxen, uart_out_flow}, 32'b110);
      chk("uart_scaler", uart_out_scaler, 32'd53);
      chk("timer1", timr_out_timer1, e_timer);
      chk("ticks", timr_out_tick, {e_t0, e_t1, 6'b0});
      chk("wdog", {timr_out_wdog, timr_out_wdogn}, {e_wdog, !e_wdog});
      chk("spi_idle", {spi_out_sck, spi_out_mosi, spi_out_miso, spi_out_io2, spi_out_io3,
                       spi_out_misooen, spi_out_mosioen, spi_out_sckoen, spi_out_io2oen,
                       spi_out_io3oen, spi_out_enable, spi_out_astart, spi_out_aready,
                       spi_out_slvsel}, 32'b0_1111_11111_001_1);
    end
  end

  // ---------------- directed / table stimulus ----------------
  typedef struct {
    logic [31:0] din, sig_in, sig_en;
    logic        rxd, ctsn;
    logic [31:0] exp_val, exp_sig;
    logic        exp_txd, exp_rtsn;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b0;
  endtask

  task automatic wait_for(input string nm, input int limit, output int cnt, input int sel);
    logic hit;
    cnt = 0;
    hit = 0;
    while (!hit && cnt < limit) begin
      @(negedge clk_i);
      cnt++;
      case (sel)
        0: hit = uart_out_txtick;
        1: hit = uart_out_rxtick;
        2: hit = (timr_out_timer1 == 32'd0);
        3: hit = timr_out_wdog;
        default: hit = (timr_out_timer1 == 32'd500);
      endcase
    end
    if (!hit) chk({nm, "_timeout"}, 32'(cnt), 32'(limit + 1));
  endtask

  initial begin
    int c;
    logic [31:0] held;

    vecs[0] = '{32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h1234_0000, 1'b1, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h3030_3030, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'hDEAD_BEEF, 32'hAAAA_5555, 32'h5555_5555, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_5555, 1'b1, 1'b1};

    rstn_i = 1'b0;
    #1 rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Reset state
    chk("rst_gpio_val", gpio_out_val, 32'h0);
    chk("rst_txd", uart_out_txd, 1'b1);
    chk("rst_slvsel", spi_out_slvsel, 1'b1);
    chk("rst_wdogn", timr_out_wdogn, 1'b1);
    chk("rst_timer1", timr_out_timer1, 32'd999);
    chk("rst_scaler", uart_out_scaler, 32'd53);
    chk("rst_ticks", {uart_out_txtick, uart_out_rxtick, timr_out_tick}, 32'h0);
    rstn_i = 1'b0;

    // Table vectors: 3-cycle latency through sync + output register
    for (int i = 0; i < 5; i++) begin
      gpio_in_din = vecs[i].din; gpio_in_sig_in = vecs[i].sig_in; gpio_in_sig_en = vecs[i].sig_en;
      uart_in_rxd = vecs[i].rxd; uart_in_ctsn = vecs[i].ctsn;
      repeat (3) @(negedge clk_i);
      chk("vec_val", gpio_out_val, vecs[i].exp_val);
      chk("vec_sig", gpio_out_sig_out, vecs[i].exp_sig);
      chk("vec_txd", uart_out_txd, vecs[i].exp_txd);
      chk("vec_rtsn", uart_out_rtsn, vecs[i].exp_rtsn);
    end

    // RX to TX loopback edge
    uart_in_rxd = 1'b1;
    repeat (4) @(negedge clk_i);
    uart_in_rxd = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("loop_txd_c2", uart_out_txd, 1'b1);
    @(negedge clk_i);
    chk("loop_txd_c3", uart_out_txd, 1'b0);

    // Baud tick period and RX/TX offset
    wait_for("txtick_a", 200, c, 0);
    wait_for("txtick_b", 200, c, 0);
    chk("txtick_period", 32'(c), 32'd54);
    wait_for("rxtick", 200, c, 1);
    wait_for("rx_to_tx", 200, c, 0);
    chk("rx_to_tx_offset", 32'(c), 32'd26);

    // Randomized traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      gpio_in_din = $urandom; gpio_in_sig_in = $urandom; gpio_in_sig_en = $urandom;
      uart_in_rxd = 1'($urandom); uart_in_ctsn = 1'($urandom);
      timr_in_wdogen = 1'($urandom);
      if ($urandom_range(7) == 0) timr_in_dhalt = ~timr_in_dhalt;
      @(negedge clk_i);
    end
    timr_in_dhalt = 1'b0;
    timr_in_wdogen = 1'b0;

    // Timer free-run from reset, underflow tick, halt freeze
    do_reset();
    wait_for("timer_zero", 1100, c, 2);
    chk("timer_zero_cycles", 32'(c), 32'd999);
    @(negedge clk_i);
    chk("underflow_tick1", timr_out_tick[1], 1'b1);
    chk("underflow_reload", timr_out_timer1, 32'd999);
    @(negedge clk_i);
    chk("tick1_single", timr_out_tick[1], 1'b0);
    timr_in_dhalt = 1'b1;
    repeat (3) @(negedge clk_i);
    held = timr_out_timer1;
    repeat (20) @(negedge clk_i);
    chk("halt_timer_frozen", timr_out_timer1, held);
    chk("halt_no_tick", timr_out_tick, 8'h00);
    timr_in_dhalt = 1'b0;

    // Watchdog: 16 enabled underflows, sticky, cleared asynchronously
    timr_in_wdogen = 1'b1;
    do_reset();
    wait_for("wdog", 17000, c, 3);
    chk("wdog_cycles", 32'(c), 32'd16000);
    chk("wdogn_low", timr_out_wdogn, 1'b0);
    timr_in_wdogen = 1'b0;
    repeat (50) @(negedge clk_i);
    chk("wdog_sticky", timr_out_wdog, 1'b1);
    #2 rstn_i = 1'b1;
    #1;
    chk("wdog_async_clr", {timr_out_wdog, timr_out_wdogn}, 32'b01);
    @(negedge clk_i);
    rstn_i = 1'b0;

    // Asynchronous reset mid-count
    wait_for("timer_500", 1100, c, 4);
    #2 rstn_i = 1'b1;
    #1;
    chk("async_timer_reload", timr_out_timer1, 32'd999);
    chk("async_txd", uart_out_txd, 1'b1);
    @(negedge clk_i);
    rstn_i = 1'b0;
    repeat (10) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
